// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port data memory.
// CPU has fixed priority; a starvation counter force-grants DMA after MAX_WAIT denials.
module data_memory_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  input  logic              cpu_req_we,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              cpu_rsp_err,

  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  input  logic              dma_req_we,
  output logic              dma_rsp_valid,
  output logic [DATA_W-1:0] dma_rsp_rdata,
  output logic              dma_rsp_err,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned CMP_W = (ADDR_W > 32) ? ADDR_W : 32;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DMA = 1'b1
  } src_e;

  // Stage-B (access) registers
  logic              r_b_valid;
  src_e              r_b_src;
  logic              r_b_we;
  logic              r_b_err;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_write_data;
  logic              r_mem_write;

  // Response registers
  logic              r_cpu_rsp_valid;
  logic [DATA_W-1:0] r_cpu_rsp_rdata;
  logic              r_cpu_rsp_err;
  logic              r_dma_rsp_valid;
  logic [DATA_W-1:0] r_dma_rsp_rdata;
  logic              r_dma_rsp_err;

  logic [CNT_W-1:0]  r_wait_cnt;

  logic              w_dma_forced;
  logic              w_cpu_grant;
  logic              w_dma_grant;
  logic              w_accept;
  src_e              w_sel_src;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_we;
  logic              w_sel_err;
  logic              w_rsp_cpu;
  logic              w_rsp_dma;
  logic              w_rsp_rd_ok;

  // Grant and request mux; ready is held low while in reset
  always_comb begin
    w_dma_forced = dma_req_valid && (r_wait_cnt == CNT_W'(MAX_WAIT));
    w_cpu_grant  = rst_n && cpu_req_valid && !w_dma_forced;
    w_dma_grant  = rst_n && dma_req_valid && (w_dma_forced || !cpu_req_valid);
    w_accept     = w_cpu_grant || w_dma_grant;
    w_sel_src    = w_dma_grant ? SRC_DMA : SRC_CPU;
    w_sel_addr   = w_dma_grant ? dma_req_addr  : cpu_req_addr;
    w_sel_wdata  = w_dma_grant ? dma_req_wdata : cpu_req_wdata;
    w_sel_we     = w_dma_grant ? dma_req_we    : cpu_req_we;
    w_sel_err    = CMP_W'(w_sel_addr) >= CMP_W'(MEM_DEPTH);
  end

  // Starvation counter: counts consecutive DMA denials, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (dma_req_valid && !w_dma_grant) begin
      if (r_wait_cnt != CNT_W'(MAX_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Stage B: latch accepted request; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid        <= 1'b0;
      r_b_src          <= SRC_CPU;
      r_b_we           <= 1'b0;
      r_b_err          <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_write      <= 1'b0;
    end else begin
      r_b_valid   <= w_accept;
      r_mem_write <= w_accept && w_sel_we && !w_sel_err;
      if (w_accept) begin
        r_b_src          <= w_sel_src;
        r_b_we           <= w_sel_we;
        r_b_err          <= w_sel_err;
        r_mem_address    <= w_sel_addr;
        r_mem_write_data <= w_sel_wdata;
      end
    end
  end

  always_comb begin
    w_rsp_cpu   = r_b_valid && (r_b_src == SRC_CPU);
    w_rsp_dma   = r_b_valid && (r_b_src == SRC_DMA);
    w_rsp_rd_ok = !r_b_we && !r_b_err;
  end

  // Response stage: capture read data at the end of the access cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rsp_valid <= 1'b0;
      r_cpu_rsp_rdata <= '0;
      r_cpu_rsp_err   <= 1'b0;
      r_dma_rsp_valid <= 1'b0;
      r_dma_rsp_rdata <= '0;
      r_dma_rsp_err   <= 1'b0;
    end else begin
      r_cpu_rsp_valid <= w_rsp_cpu;
      r_cpu_rsp_err   <= w_rsp_cpu && r_b_err;
      r_cpu_rsp_rdata <= (w_rsp_cpu && w_rsp_rd_ok) ? mem_read_data : '0;
      r_dma_rsp_valid <= w_rsp_dma;
      r_dma_rsp_err   <= w_rsp_dma && r_b_err;
      r_dma_rsp_rdata <= (w_rsp_dma && w_rsp_rd_ok) ? mem_read_data : '0;
    end
  end

  assign cpu_req_ready  = w_cpu_grant;
  assign dma_req_ready  = w_dma_grant;
  assign cpu_rsp_valid  = r_cpu_rsp_valid;
  assign cpu_rsp_rdata  = r_cpu_rsp_rdata;
  assign cpu_rsp_err    = r_cpu_rsp_err;
  assign dma_rsp_valid  = r_dma_rsp_valid;
  assign dma_rsp_rdata  = r_dma_rsp_rdata;
  assign dma_rsp_err    = r_dma_rsp_err;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign mem_write      = r_mem_write;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized bench for data_memory_arbiter: a transaction-level model predicts
// grants, memory writes and responses; a simple array stands in for the memory.
module tb_data_memory_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned MAXW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [AW-1:0] cpu_req_addr;
  logic [DW-1:0] cpu_req_wdata;
  logic          cpu_rsp_valid, cpu_rsp_err;
  logic [DW-1:0] cpu_rsp_rdata;
  logic          dma_req_valid, dma_req_ready, dma_req_we;
  logic [AW-1:0] dma_req_addr;
  logic [DW-1:0] dma_req_wdata;
  logic          dma_rsp_valid, dma_rsp_err;
  logic [DW-1:0] dma_rsp_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write;
  logic [DW-1:0] mem_read_data;

  data_memory_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_we(cpu_req_we),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata), .dma_req_we(dma_req_we),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata), .dma_rsp_err(dma_rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory stand-in: synchronous write, combinational read
  logic          mem_clr;
  logic [DW-1:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) tb_mem[i] <= '0;
    end else if (mem_write && (mem_address < 16'(DEPTH))) begin
      tb_mem[mem_address[9:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = (mem_address < 16'(DEPTH)) ? tb_mem[mem_address[9:0]] : '0;

  typedef struct {
    int            due;
    bit            dma;
    logic [DW-1:0] rdata;
    bit            err;
  } rsp_t;

  rsp_t          rq[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            wcnt_m   = 0;
  int            p_cpu    = 0;
  int            p_dma    = 0;
  int            forced_seen = 0;
  bit            exp_mw   = 0;
  logic [AW-1:0] exp_ma;
  logic [DW-1:0] exp_md;

  // Pending requester transactions (held until accepted)
  bit            cp_v, dp_v, cp_we, dp_we;
  logic [AW-1:0] cp_a, dp_a;
  logic [DW-1:0] cp_d, dp_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(3))
      0:       return 16'h0010 + 16'($urandom_range(7));
      1:       return 16'($urandom_range(DEPTH - 1));
      2:       return 16'h0400 + 16'($urandom_range(3));
      default: return 16'hFFFF;
    endcase
  endfunction

  // Transaction-level effect of one accepted request
  task automatic model_accept(input bit is_dma, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input bit we);
    rsp_t r;
    r.due   = cyc + 2;
    r.dma   = is_dma;
    r.err   = (int'(a) >= int'(DEPTH));
    r.rdata = '0;
    if (!r.err) begin
      if (we) begin
        ref_mem[a[9:0]] = d;
        exp_mw = 1;
        exp_ma = a;
        exp_md = d;
      end else begin
        r.rdata = ref_mem[a[9:0]];
      end
    end
    rq.push_back(r);
  endtask

  task automatic drive_reqs();
    cpu_req_valid = cp_v; cpu_req_addr = cp_a; cpu_req_wdata = cp_d; cpu_req_we = cp_we;
    dma_req_valid = dp_v; dma_req_addr = dp_a; dma_req_wdata = dp_d; dma_req_we = dp_we;
  endtask

  task automatic step();
    bit e_cv, e_dv, e_cerr, e_derr, forced, ec, ed;
    logic [DW-1:0] e_crd, e_drd;
    rsp_t r;
    @(negedge clk);
    if (!cp_v && ($urandom_range(99) < p_cpu)) begin
      cp_v = 1; cp_a = rand_addr(); cp_d = 16'($urandom); cp_we = 1'($urandom);
    end
    if (!dp_v && ($urandom_range(99) < p_dma)) begin
      dp_v = 1; dp_a = rand_addr(); dp_d = 16'($urandom); dp_we = 1'($urandom);
    end
    drive_reqs();
    #1;
    e_cv = 0; e_dv = 0; e_cerr = 0; e_derr = 0; e_crd = '0; e_drd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.dma) begin e_dv = 1; e_drd = r.rdata; e_derr = r.err; end
      else       begin e_cv = 1; e_crd = r.rdata; e_cerr = r.err; end
    end
    check("cpu_rsp_valid", 32'(cpu_rsp_valid), 32'(e_cv));
    check("dma_rsp_valid", 32'(dma_rsp_valid), 32'(e_dv));
    if (e_cv) begin
      check("cpu_rsp_rdata", 32'(cpu_rsp_rdata), 32'(e_crd));
      check("cpu_rsp_err",   32'(cpu_rsp_err),   32'(e_cerr));
    end
    if (e_dv) begin
      check("dma_rsp_rdata", 32'(dma_rsp_rdata), 32'(e_drd));
      check("dma_rsp_err",   32'(dma_rsp_err),   32'(e_derr));
    end
    check("mem_write", 32'(mem_write), 32'(exp_mw));
    if (exp_mw) begin
      check("mem_address",    32'(mem_address),    32'(exp_ma));
      check("mem_write_data", 32'(mem_write_data), 32'(exp_md));
    end
    forced = dp_v && (wcnt_m == int'(MAXW));
    ec = cp_v && !forced;
    ed = dp_v && (forced || !cp_v);
    check("cpu_req_ready", 32'(cpu_req_ready), 32'(ec));
    check("dma_req_ready", 32'(dma_req_ready), 32'(ed));
    exp_mw = 0;
    if (ec) begin model_accept(0, cp_a, cp_d, cp_we); cp_v = 0; end
    if (ed) begin
      if (cp_v) forced_seen++;
      model_accept(1, dp_a, dp_d, dp_we); dp_v = 0;
    end
    if (dp_v) wcnt_m = (wcnt_m < int'(MAXW)) ? wcnt_m + 1 : wcnt_m;
    else      wcnt_m = 0;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_ready"}, 32'(cpu_req_ready), 0);
    check({tag, "_dma_ready"}, 32'(dma_req_ready), 0);
    check({tag, "_rsp_valid"}, 32'({cpu_rsp_valid, dma_rsp_valid}), 0);
    check({tag, "_rsp_err"},   32'({cpu_rsp_err, dma_rsp_err}), 0);
    check({tag, "_rsp_rdata"}, 32'({cpu_rsp_rdata, dma_rsp_rdata}), 0);
    check({tag, "_mem_write"}, 32'(mem_write), 0);
    check({tag, "_mem_addr"},  32'(mem_address), 0);
    check({tag, "_mem_wdata"}, 32'(mem_write_data), 0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    cp_v = 0; dp_v = 0; cp_we = 0; dp_we = 0;
    cp_a = '0; dp_a = '0; cp_d = '0; dp_d = '0;
    drive_reqs();
    rst_n = 0; mem_clr = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1; mem_clr = 0;

    // Write then read the same address back-to-back
    cp_v = 1; cp_a = 16'h0010; cp_d = 16'hBEEF; cp_we = 1;
    step();
    cp_v = 1; cp_a = 16'h0010; cp_we = 0;
    step();
    repeat (4) step();

    // Simultaneous requests: CPU first, DMA the next cycle
    cp_v = 1; cp_a = 16'h0011; cp_we = 0;
    dp_v = 1; dp_a = 16'h0012; dp_d = 16'h1234; dp_we = 1;
    repeat (6) step();

    // Out-of-range DMA write then read
    dp_v = 1; dp_a = 16'h0400; dp_d = 16'hA5A5; dp_we = 1;
    step();
    dp_v = 1; dp_a = 16'h0400; dp_we = 0;
    repeat (5) step();

    // CPU saturating the port: DMA must still get through
    p_cpu = 100; p_dma = 100;
    repeat (40) step();
    check("dma_forced_seen", 32'(forced_seen > 0), 1);
    p_cpu = 0; p_dma = 0;
    repeat (4) step();

    // Random mix
    p_cpu = 50; p_dma = 50;
    repeat (400) step();
    p_cpu = 0; p_dma = 0;
    repeat (4) step();

    // Reset during the access cycle of an accepted read
    cp_v = 1; cp_a = 16'h0010; cp_we = 0;
    step();
    @(negedge clk);
    rst_n = 0;
    cp_v = 0; dp_v = 0;
    drive_reqs();
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst2");
    rst_n = 1;
    rq.delete();
    wcnt_m = 0;
    exp_mw = 0;
    cyc += 2;
    repeat (4) step();
    cp_v = 1; cp_a = 16'h0010; cp_we = 0;
    repeat (4) step();

    // More random traffic after reset
    p_cpu = 60; p_dma = 60;
    repeat (200) step();
    p_cpu = 0; p_dma = 0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
